// File: rtl/trng_ctrl.sv
// rtl/trng_ctrl.sv - warm-up, sampling and word assembly sequencer for trng_32x3
//
// Purpose:
//   Enables the ring oscillators and waits WARMUP_CYCLES before sampling.
//   It then takes one raw bit every SAMPLE_DIV cycles and packs WORD_WIDTH
//   accepted bits MSB-first into a word. The word is offered on a valid/ready
//   stream. The oscillators keep running while a word waits for the consumer.
//
// Ports:
//   clk       - clock, shared with the TRNG sampling clock
//   reset     - asynchronous, active-high reset
//   enable_i  - run request; low returns to IDLE and stops the oscillators
//   trng_en   - oscillator enable to trng_32x3
//   trng_out  - registered raw bit from trng_32x3
//   data_o    - assembled word, meaningful while valid_o is high
//   valid_o   - word available
//   ready_i   - consumer accepts the word
//   busy_o    - high while warming up or collecting
//
// Optional feature:
//   TRNG_VON_NEUMANN_EN - Von Neumann debiasing on consecutive raw sample pairs
module trng_ctrl #(
  parameter int WARMUP_CYCLES = 256,
  parameter int SAMPLE_DIV    = 4,
  parameter int WORD_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_i,
  output logic                  trng_en,
  input  logic                  trng_out,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o
);

  localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int BW = $clog2(WORD_WIDTH);

  localparam logic [WW-1:0] WU_LAST  = WW'(WARMUP_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_WIDTH - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WARMUP  = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  trng_en_q, trng_en_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [WW-1:0]         warm_q, warm_d;
  logic [DW-1:0]         div_q, div_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  strobe;
  logic                  take;
  logic                  samp_bit;
`ifdef TRNG_VON_NEUMANN_EN
  logic                  pair_q, pair_d;
  logic                  first_q, first_d;
`endif

  assign strobe = (state_q == S_COLLECT) && (div_q == DIV_LAST);

  // Decide whether this strobe yields an accepted bit, and which value.
  always_comb begin
    take     = 1'b0;
    samp_bit = trng_out;
`ifdef TRNG_VON_NEUMANN_EN
    pair_d   = pair_q;
    first_d  = first_q;
    if (strobe) begin
      if (!pair_q) begin
        first_d = trng_out;
        pair_d  = 1'b1;
      end else begin
        pair_d   = 1'b0;
        take     = (first_q != trng_out);
        samp_bit = first_q;
      end
    end
`else
    take = strobe;
`endif
  end

  always_comb begin
    state_d   = state_q;
    trng_en_d = trng_en_q;
    valid_d   = valid_q;
    data_d    = data_q;
    shift_d   = shift_q;
    warm_d    = warm_q;
    div_d     = div_q;
    bit_d     = bit_q;

    case (state_q)
      S_IDLE: begin
        trng_en_d = 1'b0;
        if (enable_i) begin
          state_d   = S_WARMUP;
          trng_en_d = 1'b1;
          warm_d    = '0;
        end
      end
      S_WARMUP: begin
        if (warm_q == WU_LAST) begin
          state_d = S_COLLECT;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          warm_d = warm_q + 1'b1;
        end
      end
      S_COLLECT: begin
        div_d = strobe ? '0 : div_q + 1'b1;
        if (take) begin
          shift_d = {shift_q[WORD_WIDTH-2:0], samp_bit};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            data_d  = {shift_q[WORD_WIDTH-2:0], samp_bit};
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      default: begin
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          state_d = S_COLLECT;
          div_d   = '0;
          bit_d   = '0;
        end
      end
    endcase

    // Dropping the run request wins over everything, including a handshake;
    // the last delivered word stays visible on data_o.
    if (state_q != S_IDLE && !enable_i) begin
      state_d   = S_IDLE;
      trng_en_d = 1'b0;
      valid_d   = 1'b0;
      data_d    = data_q;
    end

    busy_d = (state_d == S_WARMUP) || (state_d == S_COLLECT);
  end

`ifdef TRNG_VON_NEUMANN_EN
  // Pair phase restarts whenever collection (re)starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_q  <= 1'b0;
      first_q <= 1'b0;
    end else if (state_d == S_COLLECT && state_q != S_COLLECT) begin
      pair_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      pair_q  <= pair_d;
      first_q <= first_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      trng_en_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
      shift_q   <= '0;
      warm_q    <= '0;
      div_q     <= '0;
      bit_q     <= '0;
    end else begin
      state_q   <= state_d;
      trng_en_q <= trng_en_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
      shift_q   <= shift_d;
      warm_q    <= warm_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
    end
  end

  assign trng_en = trng_en_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign data_o  = data_q;

endmodule
